// File: rtl/carry_resolver_pkg.sv
// carry_resolver_pkg: FSM state encoding and default datapath width for carry_resolver.
package carry_resolver_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/carry_resolver.sv
// carry_resolver: folds a half-adder carry vector into its sum vector until no carry remains.
// Optional RESOLVER_ITER_CNT_EN exposes the per-result fold count on iter_cnt.
module carry_resolver
    import carry_resolver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef RESOLVER_ITER_CNT_EN
   ,output logic [CNT_W-1:0] iter_cnt
`endif
);
    state_t           state;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic             cout;
    logic [WIDTH-1:0] c_sh;

    // The shift drops c's MSB; it is captured into cout in the same update.
    assign c_sh = c << 1;

`ifdef RESOLVER_ITER_CNT_EN
    logic [CNT_W-1:0] cnt;
    assign iter_cnt = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == IDLE && in_valid)
            cnt <= '0;
        else if (state == RESOLVE && c != '0)
            cnt <= cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            s         <= '0;
            c         <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    s        <= in_d;
                    c        <= in_c;
                    cout     <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= RESOLVE;
                end
                RESOLVE: if (c == '0) begin
                    out_sum   <= s;
                    out_cout  <= cout;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    cout <= cout | c[WIDTH-1];
                    s    <= s ^ c_sh;
                    c    <= s & c_sh;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_carry_resolver.sv
// tb_carry_resolver: directed and randomized checks of carry_resolver against plain-addition expectations.
// Define RESOLVER_ITER_CNT_EN to also check iter_cnt.
module tb_carry_resolver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_d = '0;
    logic [7:0] in_c = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_cout;
`ifdef RESOLVER_ITER_CNT_EN
    logic [3:0] iter_cnt;
`endif
    int vectors = 0;
    int errors = 0;

    carry_resolver dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef RESOLVER_ITER_CNT_EN
       ,.iter_cnt(iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        vectors += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum got %h want 00", out_sum); end
        if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
    endtask

    // Accepts one pair, waits for the result, holds out_ready low for `hold` cycles, then drains it.
    task automatic run_txn(input logic [7:0] d, input logic [7:0] c, input int hold,
                           input int exp_lat, input int exp_iter, input string name);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, d} + {c, 1'b0};
        out_ready = (hold == 0);
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
        in_d = d;
        in_c = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_d = ~d;
        in_c = 8'hA5;
        lat = 1;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        vectors += 3;
        if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
        if (out_sum !== exp[7:0]) begin errors++; $display("FAIL %s_sum got %h want %h", name, out_sum, exp[7:0]); end
        if (out_cout !== exp[8]) begin errors++; $display("FAIL %s_cout got %b want %b", name, out_cout, exp[8]); end
`ifdef RESOLVER_ITER_CNT_EN
        vectors++;
        if (iter_cnt !== 4'(exp_iter)) begin errors++; $display("FAIL %s_iter_cnt got %0d want %0d", name, iter_cnt, exp_iter); end
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp)
                begin errors++; $display("FAIL %s_stall%0d got v=%b r=%b %b_%h want v=1 r=0 %h", name, i, out_valid, in_ready, out_cout, out_sum, exp); end
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL %s_drain got v=%b r=%b want v=0 r=1", name, out_valid, in_ready); end
        if (exp_iter < 0) ;
    endtask

    task automatic test_directed();
        run_txn(8'h0E, 8'h01, 0, 6, 4, "carry_ripple");
        run_txn(8'h5A, 8'h00, 0, 2, 0, "zero_carry");
        run_txn(8'hFE, 8'h01, 0, 10, 8, "worst_case");
    endtask

    task automatic test_stall();
        run_txn(8'h00, 8'hFF, 5, 3, 1, "stall");
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        in_d = 8'hFE;
        in_c = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_async got v=%b want 0", out_valid); end
        step();
        rst_n = 1'b1;
        step();
        vectors += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        if (out_sum !== 8'h00) begin errors++; $display("FAIL abort_out_sum got %h want 00", out_sum); end
        if (out_cout !== 1'b0) begin errors++; $display("FAIL abort_out_cout got %b want 0", out_cout); end
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin errors++; $display("FAIL abort_idle%0d got v=%b r=%b want v=0 r=1", i, out_valid, in_ready); end
        end
        run_txn(8'h03, 8'h00, 0, 2, 0, "post_abort");
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic [8:0] exp;
        int outs = 0;
        int cyc;
        bit fire, got;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            exp = {1'b0, a} + {1'b0, b};
            cyc = 0;
            while (!in_ready && cyc < 20) begin step(); cyc++; end
            in_d = a ^ b;
            in_c = a & b;
            in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            step();
            in_valid = 1'b0;
            in_d = 8'($urandom);
            in_c = 8'($urandom);
            got = 1'b0;
            cyc = 0;
            while (!got && cyc < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                fire = out_valid && out_ready;
                if (fire) begin
                    outs++;
                    vectors++;
                    if ({out_cout, out_sum} !== exp)
                        begin errors++; $display("FAIL random%0d a=%h b=%h got %b_%h want %h", n, a, b, out_cout, out_sum, exp); end
                end
                step();
                cyc++;
                got = fire;
            end
            vectors++;
            if (!got || out_valid !== 1'b0)
                begin errors++; $display("FAIL random%0d_handshake got done=%b v=%b want done=1 v=0", n, got, out_valid); end
        end
        vectors++;
        if (outs !== 1000) begin errors++; $display("FAIL random_count got %0d want 1000", outs); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
